// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding and load-use hazard control.
package hazard_forward_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned SEL_W      = 2;

    localparam logic [SEL_W-1:0] FWD_RF    = 2'd0;
    localparam logic [SEL_W-1:0] FWD_EXMEM = 2'd1;
    localparam logic [SEL_W-1:0] FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memread;
        logic [REG_ADDR_W-1:0] dest;
    } slot_t;

    // Register 0 is hardwired, so writes to it never feed a consumer.
    function automatic logic is_producer(input slot_t s);
        return s.valid & s.regwrite & (s.dest != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// Selects the forwarding source for one source operand against the EX and MEM producers.
module hazard_forward_unit_fwd_match
    import hazard_forward_unit_pkg::*;
(
    input  logic                  i_uses,
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_ex_prod,
    input  logic [REG_ADDR_W-1:0] i_ex_dest,
    input  logic                  i_mem_prod,
    input  logic [REG_ADDR_W-1:0] i_mem_dest,
    output logic [SEL_W-1:0]      o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_uses & i_ex_prod  & (i_src == i_ex_dest);
    assign w_mem_hit = i_uses & i_mem_prod & (i_src == i_mem_dest);

    // The EX-slot producer is the younger one, so it wins over MEM.
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks in-flight destinations, registers EX operand forward selects and raises load-use stalls.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_regwrite,
    input  logic                  i_id_memread,
    input  logic                  i_flush,
    output logic [SEL_W-1:0]      o_fwd_a,
    output logic [SEL_W-1:0]      o_fwd_b,
    output logic                  o_stall,
    output logic                  o_pc_write,
    output logic                  o_ifid_write
);

    slot_t                 r_ex;
    slot_t                 w_id_slot;
    logic                  w_ex_prod;
    logic                  w_stall;
    logic                  w_accept;
    logic [SEL_W-1:0]      w_sel_a;
    logic [SEL_W-1:0]      w_sel_b;
    logic [SEL_W-1:0]      r_fwd_a;
    logic [SEL_W-1:0]      r_fwd_b;

    // MEM keeps only what forwarding consumes; the WB slot is not stored at all because the
    // register file is write-before-read, so a WB producer never needs a forward.
    logic                  r_mem_prod;
    logic [REG_ADDR_W-1:0] r_mem_dest;

    assign w_id_slot = '{valid:    i_id_valid,
                         regwrite: i_id_regwrite,
                         memread:  i_id_memread,
                         dest:     i_id_rd};

    assign w_ex_prod = is_producer(r_ex);

    // FLUSH squashes the ID instruction, so there is nothing left to stall for.
    assign w_stall = i_id_valid & ~i_flush & w_ex_prod & r_ex.memread &
                     ((i_id_uses_rs & (i_id_rs == r_ex.dest)) |
                      (i_id_uses_rt & (i_id_rt == r_ex.dest)));

    assign w_accept = i_id_valid & ~w_stall & ~i_flush;

    hazard_forward_unit_fwd_match u_match_a (
        .i_uses     (i_id_uses_rs),
        .i_src      (i_id_rs),
        .i_ex_prod  (w_ex_prod),
        .i_ex_dest  (r_ex.dest),
        .i_mem_prod (r_mem_prod),
        .i_mem_dest (r_mem_dest),
        .o_sel      (w_sel_a)
    );

    hazard_forward_unit_fwd_match u_match_b (
        .i_uses     (i_id_uses_rt),
        .i_src      (i_id_rt),
        .i_ex_prod  (w_ex_prod),
        .i_ex_dest  (r_ex.dest),
        .i_mem_prod (r_mem_prod),
        .i_mem_dest (r_mem_dest),
        .o_sel      (w_sel_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex       <= '0;
            r_mem_prod <= 1'b0;
            r_mem_dest <= '0;
            r_fwd_a    <= FWD_RF;
            r_fwd_b    <= FWD_RF;
        end else begin
            r_mem_prod <= w_ex_prod;
            r_mem_dest <= r_ex.dest;
            if (w_accept) begin
                r_ex    <= w_id_slot;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end else begin
                r_ex    <= '0;
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end
        end
    end

    assign o_fwd_a      = r_fwd_a;
    assign o_fwd_b      = r_fwd_b;
    assign o_stall      = w_stall;
    assign o_pc_write   = ~w_stall;
    assign o_ifid_write = ~w_stall;

endmodule
